imm_gen_stage: RTL
==================

Name: imm_gen_stage

Overview:
- Registered, handshaked immediate-generation stage for the decode pipeline.
- Classifies each 32-bit RV instruction by opcode and emits the selected immediate sign-extended to XLEN, plus a format code and illegal flag.
- Full-throughput valid/ready pipeline stage with a 2-entry skid buffer; sits between fetch queue and register-read.
- Generalises the fixed 32-bit, all-formats-in-parallel extender to parametrised XLEN, automatic format selection, a tag sideband and flush.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 8, width of the opaque sideband tag carried alongside each instruction (PC index, ROB id, etc.).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstN  input  1  reset; synchronous, active-low.
- flush  input  1  synchronous pipeline flush; kills all held entries.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage can accept; registered signal.
- in_instr  input  32  raw instruction word.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts result.
- out_imm  output  XLEN  sign-extended immediate.
- out_fmt  output  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 NONE.
- out_illegal  output  1  opcode not recognised.
- out_tag  output  TAG_W  tag of the presented result.

Behaviour:
- Reset (rstN=0 at clk edge): main and skid entries invalid; out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Latency: an accepted instruction appears on out_* the next cycle when the main entry is empty or draining; throughput is 1 per cycle.
- Skid: if the main entry is full, out_ready=0 and an input is accepted in the same cycle, the input goes to the skid entry and in_ready deasserts next cycle. When the main entry drains, skid moves to main and in_ready reasserts the following cycle.
- Ordering is strictly FIFO.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Decode by instr[6:0]:
  - 0000011, 0010011, 1100111, 1110011 → I; imm = instr[31:20].
  - 0100011 → S; imm = {instr[31:25], instr[11:7]}.
  - 1100011 → B; imm = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - 0110111, 0010111 → U; imm = {instr[31:12], 12'b0}.
  - 1101111 → J; imm = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - 0110011 → R; imm = 0.
  - Any other opcode → NONE, imm = 0, out_illegal = 1.
- All immediates are sign-extended from their top bit to XLEN; U is also sign-extended from bit 31 when XLEN=64.
- Decode is combinational on in_instr; results are stored at acceptance.
- Flush: at the edge with flush=1, both entries are invalidated, out_valid=0 next cycle and in_ready=1 next cycle. A same-cycle input is dropped; flush has priority over accept and transfer-out.
- rstN=0 mid-stall has the same effect as reset; it overrides flush.

Optional Feature:
- Macro: IMM_GEN_ZIMM_EN.
- Defined: opcode 1110011 with instr[14]=1 (CSRRWI/CSRRSI/CSRRCI) → fmt Z; imm = zero-extended instr[19:15]. Opcode 1110011 with instr[14]=0 stays I.
- Undefined: all 1110011 decode as I; fmt code 6 is never produced.

Test Plan:
- ADDI x1,x0,-1 (0xFFF00093), XLEN=32 → after 1 cycle: out_imm=0xFFFFFFFF, fmt=1, illegal=0. With XLEN=64 → out_imm=0xFFFFFFFFFFFFFFFF.
- Back-to-back stream, out_ready=1:
  - LUI 0x12345037 → 0x12345000, fmt 4.
  - BEQ -4 0xFE000EE3 → 0xFFFFFFFC, fmt 3.
  - JAL 8 0x0080006F → 0x00000008, fmt 5.
  - Required: one result per cycle, tags in order.
- Backpressure: hold out_ready=0 for 3 cycles while offering 3 instructions → only 2 accepted and in_ready=0 from cycle 2. Release → both drain in order, no loss or duplication.
- Flush while both entries are full and in_valid=1 → next cycle out_valid=0, in_ready=1; flushed tags never appear.
- Illegal opcode 0x0000007F → fmt=7, illegal=1, imm=0. Store SW x2,-8(x1) (0xFE20AC23) → imm=0xFFFFFFF8, fmt=2.
- IMM_GEN_ZIMM_EN defined: CSRRWI x0,mstatus,31 (0x300FD073) → fmt=6, imm=0x0000001F. Undefined → fmt=1, imm=0x00000300.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Registered valid/ready immediate-generation stage with a 2-entry skid buffer.
// Decodes the opcode of each RV32 instruction, selects the immediate format and
// sign-extends it to XLEN. A tag sideband travels with every instruction.
// Optional feature macro: IMM_GEN_ZIMM_EN (CSR*I zero-extended uimm, fmt Z).
module imm_gen_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 8
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FmtR    = 3'd0;
  localparam logic [2:0] FmtI    = 3'd1;
  localparam logic [2:0] FmtS    = 3'd2;
  localparam logic [2:0] FmtB    = 3'd3;
  localparam logic [2:0] FmtU    = 3'd4;
  localparam logic [2:0] FmtJ    = 3'd5;
`ifdef IMM_GEN_ZIMM_EN
  localparam logic [2:0] FmtZ    = 3'd6;
`endif
  localparam logic [2:0] FmtNone = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [31:0] dec_imm32;
  logic [2:0]  dec_fmt;
  logic        dec_illegal;
  entry_t      dec_entry;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   in_fire, out_fire;

  // Opcode classification and 32-bit immediate assembly.
  always_comb begin
    dec_imm32   = 32'd0;
    dec_fmt     = FmtNone;
    dec_illegal = 1'b0;
    case (in_instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: begin
        dec_fmt   = FmtI;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      7'b1110011: begin
`ifdef IMM_GEN_ZIMM_EN
        if (in_instr[14]) begin
          dec_fmt   = FmtZ;
          dec_imm32 = {27'd0, in_instr[19:15]};
        end else begin
          dec_fmt   = FmtI;
          dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
`else
        dec_fmt   = FmtI;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
`endif
      end
      7'b0100011: begin
        dec_fmt   = FmtS;
        dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      7'b1100011: begin
        dec_fmt   = FmtB;
        dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt   = FmtU;
        dec_imm32 = {in_instr[31:12], 12'd0};
      end
      7'b1101111: begin
        dec_fmt   = FmtJ;
        dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_fmt   = FmtR;
      end
      default: begin
        dec_fmt     = FmtNone;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Widen to XLEN (U included: bit 31 is its sign) and bundle with the tag.
  always_comb begin
    dec_entry.imm     = XLEN'($signed(dec_imm32));
    dec_entry.fmt     = dec_fmt;
    dec_entry.illegal = dec_illegal;
    dec_entry.tag     = in_tag;
  end

  assign in_ready = ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid_q & out_ready;

  // Next-state for main/skid entries; flush beats accept and transfer-out.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_fire) begin
      // in_ready is low whenever skid holds data, so no input can arrive here
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        main_d       = dec_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec_entry;
      skid_valid_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = main_valid_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_illegal = main_q.illegal;
  assign out_tag     = main_q.tag;

endmodule
